id_ex_reg: RTL and testbench
============================

# id_ex_reg

Pipeline register between decode and execute of the RV32 core. Captures the control bundle from the decode control unit together with PC, register-file operands, immediate and register indices, and presents them registered to EX. Owns the pipeline's stall/flush/bubble policy at this boundary, including load-use hazard detection.

## Interface
- No parameters; data width is fixed at 32, ALU op at 4 bits.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID slot holds a real instruction.
- `id_pc`, `id_instr`, `id_rs1_data`, `id_rs2_data`, `id_imm` in 32 each: decode-stage payload.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: instruction reads rs1/rs2.
- `dec_reg_write`, `dec_is_load`, `dec_is_store`, `dec_is_branch`, `dec_is_jal`, `dec_is_jalr`, `dec_opa_sel`, `dec_opb_sel` in 1 each: control from decode.
- `dec_mem_to_reg` in 2; `dec_alu_op` in 4.
- `ex_stall` in 1: EX cannot accept a new instruction this cycle.
- `flush` in 1: redirect from EX; kill the ID instruction and whatever is being written here.
- `id_stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid` out 1; `ex_pc`, `ex_rs1_data`, `ex_rs2_data`, `ex_imm` out 32.
- `ex_rd`, `ex_rs1`, `ex_rs2` out 5; `ex_funct3` out 3.
- `ex_reg_write`, `ex_is_load`, `ex_is_store`, `ex_is_branch`, `ex_is_jal`, `ex_is_jalr`, `ex_opa_sel`, `ex_opb_sel` out 1; `ex_mem_to_reg` out 2; `ex_alu_op` out 4.

## Operation
- Field extraction: rd = `id_instr[11:7]`, rs1 = `[19:15]`, rs2 = `[24:20]`, funct3 = `[14:12]`.
- Captured `ex_rd` is forced to 0 when `dec_reg_write`=0 or `id_valid`=0; `ex_rs1`/`ex_rs2` forced to 0 when the corresponding `id_uses_*`=0.
- Load-use hazard (`lu`) = `ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_uses_rs1 & rs1==ex_rd) | (id_uses_rs2 & rs2==ex_rd))`.
- Per-edge priority, highest first:
  - `rst`: all outputs 0.
  - `flush`: bubble (`ex_valid`=0, every control output 0, data outputs don't-care but driven 0); overrides `ex_stall`.
  - `ex_stall`: hold all registers unchanged.
  - `lu`: insert bubble, same as the flush contents.
  - else: capture; `ex_valid` = `id_valid`; control outputs gated to 0 when `id_valid`=0.
- `id_stall` = `(ex_stall | lu) & ~flush`, combinational.
- A bubble never has `ex_reg_write`, `ex_is_store` or `ex_is_branch` set; EX may rely on this without checking `ex_valid`.

## Timing
- Latency: one cycle from ID inputs to `ex_*`.
- `id_stall` is combinational from registered `ex_*` state plus the same-cycle `id_*`/`ex_stall`/`flush`; there is no path from `id_stall` back into itself.
- Load-use costs exactly one bubble. On the next cycle `ex_is_load`=0, `lu` drops, and the dependent instruction is captured while the load sits in MEM for forwarding.
- `lu` concurrent with `ex_stall`: hold takes precedence; the bubble is inserted only once `ex_stall` deasserts.
- Reset during a stall or bubble: the outputs clear on that edge and `id_stall` falls to `ex_stall` on the next cycle.

## Configuration
- `AQUILA_LOAD_USE_EN` defined: `lu` is detected and handled as above.
- Undefined: `lu` is tied to 0 and `id_stall` = `ex_stall & ~flush`. The core must then tolerate load-use hazards by other means (e.g. software NOP scheduling).

## Structure
- Shared package `aquila_pkg`:
  - ALU op encodings (4-bit).
  - `mem_to_reg` encodings (ALU/MEM/PC+4).
  - Opcode constants.
  - A packed control-bundle typedef used by both decode and this block.
- One sub-module, `hazard_unit`: combinational `lu` computation, instantiated only under `AQUILA_LOAD_USE_EN`.

## Test plan
- Reset: assert `rst` with `id_valid`=1 -> next cycle `ex_valid`=0 and all `ex_*`=0, `id_stall`=0.
- Normal flow: add x3,x1,x2 at pc=0x100 with `dec_alu_op`=ADD -> next cycle `ex_valid`=1, `ex_pc`=0x100, `ex_rd`=3, `ex_rs1`=1, `ex_rs2`=2, `ex_reg_write`=1.
- Load-use: `lw x5,0(x1)` followed by `add x6,x5,x2`:
  - With the lw in EX -> `id_stall`=1, next cycle `ex_valid`=0.
  - Following cycle -> `ex_rd`=6.
  - With `AQUILA_LOAD_USE_EN` undefined -> no stall.
- Load to x0: `lw x0,...` followed by `add x6,x0,x2` -> `id_stall`=0, no bubble.
- Stall hold: `ex_stall`=1 for 3 cycles with changing ID inputs -> `ex_*` unchanged throughout, `id_stall`=1.
- Flush priority: `flush`=1 and `ex_stall`=1 together with a valid store in ID -> next cycle `ex_valid`=0, `ex_is_store`=0, `id_stall`=0.

Source files
------------

// File: rtl/aquila_pkg.sv
// ============================================================================
// Module      : aquila_pkg
// Description : Shared RV32 encodings and the decode control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aquila_pkg;

    localparam logic [3:0] C_ALU_ADD  = 4'd0;
    localparam logic [3:0] C_ALU_SUB  = 4'd1;
    localparam logic [3:0] C_ALU_SLL  = 4'd2;
    localparam logic [3:0] C_ALU_SLT  = 4'd3;
    localparam logic [3:0] C_ALU_SLTU = 4'd4;
    localparam logic [3:0] C_ALU_XOR  = 4'd5;
    localparam logic [3:0] C_ALU_SRL  = 4'd6;
    localparam logic [3:0] C_ALU_SRA  = 4'd7;
    localparam logic [3:0] C_ALU_OR   = 4'd8;
    localparam logic [3:0] C_ALU_AND  = 4'd9;
    localparam logic [3:0] C_ALU_PASS = 4'd10;

    localparam logic [1:0] C_WB_ALU = 2'd0;
    localparam logic [1:0] C_WB_MEM = 2'd1;
    localparam logic [1:0] C_WB_PC4 = 2'd2;

    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic       reg_write;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jal;
        logic       is_jalr;
        logic       opa_sel;
        logic       opb_sel;
        logic [1:0] mem_to_reg;
        logic [3:0] alu_op;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module      : hazard_unit
// Description : Combinational load-use detection between EX and ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_unit (
    input  logic       i_ex_valid,
    input  logic       i_ex_is_load,
    input  logic [4:0] i_ex_rd,
    input  logic       i_id_valid,
    input  logic       i_uses_rs1,
    input  logic       i_uses_rs2,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    output logic       o_lu
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1 = i_uses_rs1 && (i_rs1 == i_ex_rd);
    assign w_hit_rs2 = i_uses_rs2 && (i_rs2 == i_ex_rd);

    // x0 is never a real dependency, so a load targeting it cannot stall.
    assign o_lu = i_ex_valid && i_ex_is_load && (i_ex_rd != 5'd0) &&
                  i_id_valid && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/id_ex_reg.sv
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register with stall/flush/bubble policy.
//               Load-use detection enabled by defining AQUILA_LOAD_USE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_reg
    import aquila_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        dec_reg_write,
    input  logic        dec_is_load,
    input  logic        dec_is_store,
    input  logic        dec_is_branch,
    input  logic        dec_is_jal,
    input  logic        dec_is_jalr,
    input  logic        dec_opa_sel,
    input  logic        dec_opb_sel,
    input  logic [1:0]  dec_mem_to_reg,
    input  logic [3:0]  dec_alu_op,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [2:0]  ex_funct3,
    output logic        ex_reg_write,
    output logic        ex_is_load,
    output logic        ex_is_store,
    output logic        ex_is_branch,
    output logic        ex_is_jal,
    output logic        ex_is_jalr,
    output logic        ex_opa_sel,
    output logic        ex_opb_sel,
    output logic [1:0]  ex_mem_to_reg,
    output logic [3:0]  ex_alu_op
);

    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_funct3;
    logic        w_unused_instr;
    ctrl_t       w_dec_ctrl;
    logic        w_lu;

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_funct3;
    ctrl_t       r_ctrl;

    assign w_rd           = id_instr[11:7];
    assign w_rs1          = id_instr[19:15];
    assign w_rs2          = id_instr[24:20];
    assign w_funct3       = id_instr[14:12];
    assign w_unused_instr = ^{id_instr[31:25], id_instr[6:0]};

    assign w_dec_ctrl = '{
        reg_write:  dec_reg_write,
        is_load:    dec_is_load,
        is_store:   dec_is_store,
        is_branch:  dec_is_branch,
        is_jal:     dec_is_jal,
        is_jalr:    dec_is_jalr,
        opa_sel:    dec_opa_sel,
        opb_sel:    dec_opb_sel,
        mem_to_reg: dec_mem_to_reg,
        alu_op:     dec_alu_op
    };

`ifdef AQUILA_LOAD_USE_EN
    hazard_unit u_hazard_unit (
        .i_ex_valid   (r_valid),
        .i_ex_is_load (r_ctrl.is_load),
        .i_ex_rd      (r_rd),
        .i_id_valid   (id_valid),
        .i_uses_rs1   (id_uses_rs1),
        .i_uses_rs2   (id_uses_rs2),
        .i_rs1        (w_rs1),
        .i_rs2        (w_rs2),
        .o_lu         (w_lu)
    );
`else
    assign w_lu = 1'b0;
`endif

    assign id_stall = (ex_stall | w_lu) & ~flush;

    // Flush beats stall; a load-use bubble only lands once EX can move.
    always_ff @(posedge clk) begin
        if (rst || flush || (!ex_stall && w_lu)) begin
            r_valid    <= 1'b0;
            r_pc       <= 32'd0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_rd       <= 5'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_funct3   <= 3'd0;
            r_ctrl     <= '0;
        end else if (!ex_stall) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rd       <= (id_valid && dec_reg_write) ? w_rd : 5'd0;
            r_rs1      <= id_uses_rs1 ? w_rs1 : 5'd0;
            r_rs2      <= id_uses_rs2 ? w_rs2 : 5'd0;
            r_funct3   <= w_funct3;
            r_ctrl     <= id_valid ? w_dec_ctrl : '0;
        end
    end

    assign ex_valid      = r_valid;
    assign ex_pc         = r_pc;
    assign ex_rs1_data   = r_rs1_data;
    assign ex_rs2_data   = r_rs2_data;
    assign ex_imm        = r_imm;
    assign ex_rd         = r_rd;
    assign ex_rs1        = r_rs1;
    assign ex_rs2        = r_rs2;
    assign ex_funct3     = r_funct3;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_is_load    = r_ctrl.is_load;
    assign ex_is_store   = r_ctrl.is_store;
    assign ex_is_branch  = r_ctrl.is_branch;
    assign ex_is_jal     = r_ctrl.is_jal;
    assign ex_is_jalr    = r_ctrl.is_jalr;
    assign ex_opa_sel    = r_ctrl.opa_sel;
    assign ex_opb_sel    = r_ctrl.opb_sel;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;
    assign ex_alu_op     = r_ctrl.alu_op;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_reg.sv
// ============================================================================
// Module      : tb_id_ex_reg
// Description : Randomized scoreboard bench for id_ex_reg.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_reg;

    typedef struct {
        logic        rst, flush, ex_stall;
        logic        valid;
        logic [31:0] pc, instr, rs1d, rs2d, imm;
        logic        u1, u2;
        logic        rw, ld, st, br, jal, jalr, opa, opb;
        logic [1:0]  m2r;
        logic [3:0]  alu;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        rw, ld, st, br, jal, jalr, opa, opb;
        logic [1:0]  m2r;
        logic [3:0]  alu;
    } exp_t;

    logic  clk = 1'b0;
    stim_t cur;
    exp_t  model_st;
    exp_t  q_state[$];
    logic  q_stall[$];
    int    tests = 0;
    int    fails = 0;
    logic  done  = 1'b0;

    logic        id_stall, ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write, ex_is_load, ex_is_store, ex_is_branch;
    logic        ex_is_jal, ex_is_jalr, ex_opa_sel, ex_opb_sel;
    logic [1:0]  ex_mem_to_reg;
    logic [3:0]  ex_alu_op;

    always #5 clk = ~clk;

    id_ex_reg dut (
        .clk(clk), .rst(cur.rst), .id_valid(cur.valid), .id_pc(cur.pc),
        .id_instr(cur.instr), .id_rs1_data(cur.rs1d), .id_rs2_data(cur.rs2d),
        .id_imm(cur.imm), .id_uses_rs1(cur.u1), .id_uses_rs2(cur.u2),
        .dec_reg_write(cur.rw), .dec_is_load(cur.ld), .dec_is_store(cur.st),
        .dec_is_branch(cur.br), .dec_is_jal(cur.jal), .dec_is_jalr(cur.jalr),
        .dec_opa_sel(cur.opa), .dec_opb_sel(cur.opb),
        .dec_mem_to_reg(cur.m2r), .dec_alu_op(cur.alu),
        .ex_stall(cur.ex_stall), .flush(cur.flush), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rd(ex_rd),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_opa_sel(ex_opa_sel), .ex_opb_sel(ex_opb_sel),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op)
    );

    // Reference rules: load-use hazard against the instruction now in EX.
    function automatic logic ref_lu(input exp_t ex, input stim_t s);
`ifdef AQUILA_LOAD_USE_EN
        return ex.valid && ex.ld && ex.rd != 5'd0 && s.valid &&
               ((s.u1 && s.instr[19:15] == ex.rd) ||
                (s.u2 && s.instr[24:20] == ex.rd));
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t ref_next(input exp_t ex, input stim_t s);
        exp_t n = '0;
        if (s.rst || s.flush) return n;
        if (s.ex_stall) return ex;
        if (ref_lu(ex, s)) return n;
        n.valid = s.valid;
        n.pc = s.pc; n.rs1d = s.rs1d; n.rs2d = s.rs2d; n.imm = s.imm;
        n.rd  = (s.valid && s.rw) ? s.instr[11:7] : 5'd0;
        n.rs1 = s.u1 ? s.instr[19:15] : 5'd0;
        n.rs2 = s.u2 ? s.instr[24:20] : 5'd0;
        n.f3  = s.instr[14:12];
        if (s.valid) begin
            n.rw = s.rw; n.ld = s.ld; n.st = s.st; n.br = s.br;
            n.jal = s.jal; n.jalr = s.jalr; n.opa = s.opa; n.opb = s.opb;
            n.m2r = s.m2r; n.alu = s.alu;
        end
        return n;
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s.rst = 0; s.flush = 0; s.ex_stall = 0; s.valid = 0;
        s.pc = 0; s.instr = 0; s.rs1d = 0; s.rs2d = 0; s.imm = 0;
        s.u1 = 0; s.u2 = 0; s.rw = 0; s.ld = 0; s.st = 0; s.br = 0;
        s.jal = 0; s.jalr = 0; s.opa = 0; s.opb = 0; s.m2r = 0; s.alu = 0;
        return s;
    endfunction

    function automatic stim_t f_add(input logic [4:0] rd, rs1, rs2, input logic [31:0] pc);
        stim_t s = blank();
        s.valid = 1; s.pc = pc; s.instr = {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
        s.rs1d = 32'h1000 + pc; s.rs2d = 32'h2000 + pc;
        s.u1 = 1; s.u2 = 1; s.rw = 1; s.alu = 4'd0;
        return s;
    endfunction

    function automatic stim_t f_lw(input logic [4:0] rd, rs1, input logic [31:0] pc);
        stim_t s = blank();
        s.valid = 1; s.pc = pc; s.instr = {12'd0, rs1, 3'b010, rd, 7'b0000011};
        s.rs1d = 32'h3000; s.u1 = 1; s.rw = 1; s.ld = 1; s.opb = 1; s.m2r = 2'd1;
        return s;
    endfunction

    function automatic stim_t f_sw(input logic [4:0] rs1, rs2, input logic [31:0] pc);
        stim_t s = blank();
        s.valid = 1; s.pc = pc; s.instr = {7'd0, rs2, rs1, 3'b010, 5'd4, 7'b0100011};
        s.imm = 32'd4; s.u1 = 1; s.u2 = 1; s.st = 1; s.opb = 1;
        return s;
    endfunction

    function automatic stim_t f_rand();
        stim_t s;
        s.rst = ($urandom_range(0, 31) == 0);
        s.flush = ($urandom_range(0, 9) == 0);
        s.ex_stall = ($urandom_range(0, 4) == 0);
        s.valid = ($urandom_range(0, 5) != 0);
        s.pc = $urandom; s.rs1d = $urandom; s.rs2d = $urandom; s.imm = $urandom;
        s.instr = $urandom;
        s.instr[11:7]  = 5'($urandom_range(0, 3));
        s.instr[19:15] = 5'($urandom_range(0, 3));
        s.instr[24:20] = 5'($urandom_range(0, 3));
        s.u1 = 1'($urandom); s.u2 = 1'($urandom);
        s.rw = 1'($urandom); s.ld = ($urandom_range(0, 2) == 0);
        s.st = 1'($urandom); s.br = 1'($urandom); s.jal = 1'($urandom);
        s.jalr = 1'($urandom); s.opa = 1'($urandom); s.opb = 1'($urandom);
        s.m2r = 2'($urandom); s.alu = 4'($urandom);
        return s;
    endfunction

    // Driver side: present one cycle of stimulus and queue the stall expectation.
    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        cur = s;
        q_stall.push_back((s.ex_stall | ref_lu(model_st, s)) & ~s.flush);
    endtask

    always @(posedge clk) begin
        model_st = ref_next(model_st, cur);
        q_state.push_back(model_st);
    end

    // Monitor: compare DUT against the queued expectations on the falling edge.
    always @(negedge clk) begin
        if (!done) begin
            if (q_stall.size() > 0) begin
                logic e;
                e = q_stall.pop_front();
                tests++;
                if (id_stall !== e) begin
                    fails++;
                    $display("FAIL id_stall @%0t: got %b expected %b", $time, id_stall, e);
                end
            end
            if (q_state.size() > 0) begin
                exp_t e, a;
                e = q_state.pop_front();
                a = '{ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
                      ex_rs1, ex_rs2, ex_funct3, ex_reg_write, ex_is_load,
                      ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr,
                      ex_opa_sel, ex_opb_sel, ex_mem_to_reg, ex_alu_op};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL ex_state @%0t: got %h expected %h", $time, a, e);
                end
            end
        end
    end

    initial begin
        stim_t s;
        model_st = '0;
        cur = f_add(5'd3, 5'd1, 5'd2, 32'h100);
        cur.rst = 1;
        apply(cur);
        apply(cur);
        apply(f_add(5'd3, 5'd1, 5'd2, 32'h100));
        apply(f_lw(5'd5, 5'd1, 32'h104));
        apply(f_add(5'd6, 5'd5, 5'd2, 32'h108));
        apply(f_add(5'd6, 5'd5, 5'd2, 32'h108));
        apply(f_add(5'd7, 5'd1, 5'd2, 32'h10c));
        apply(f_lw(5'd0, 5'd1, 32'h110));
        apply(f_add(5'd6, 5'd0, 5'd2, 32'h114));
        apply(f_add(5'd8, 5'd1, 5'd2, 32'h118));
        for (int i = 0; i < 3; i++) begin
            s = f_add(5'(9 + i), 5'd1, 5'd2, 32'h200 + 32'(i * 4));
            s.ex_stall = 1;
            apply(s);
        end
        apply(f_lw(5'd2, 5'd1, 32'h120));
        s = f_sw(5'd1, 5'd2, 32'h124);
        s.flush = 1; s.ex_stall = 1;
        apply(s);
        s = f_add(5'd3, 5'd2, 5'd2, 32'h128);
        s.ex_stall = 1; s.rst = 1;
        apply(s);
        apply(f_add(5'd3, 5'd1, 5'd2, 32'h12c));
        for (int i = 0; i < 600; i++) apply(f_rand());
        repeat (2) @(negedge clk);
        #1;
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
